// File: rtl/maxnet_frontend_if.sv
// Stream bundle between host and the Maxnet frontend: operand words in, result words out.
interface maxnet_frontend_if #(
  parameter int unsigned W = 32
) ();
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_err;

  // Host side: produces operand words, consumes results.
  modport master (
    output in_valid, in_data, res_ready,
    input  in_ready, res_valid, res_data, res_err
  );

  // Frontend side.
  modport slave (
    input  in_valid, in_data, res_ready,
    output in_ready, res_valid, res_data, res_err
  );
endinterface

// File: rtl/maxnet_frontend.sv
// Maxnet host-side frontend: gathers a five-word frame, kicks the core, waits for a fresh
// finish (or a watchdog abort) and hands the captured result back on a valid/ready stream.
module maxnet_frontend #(
  parameter int unsigned W       = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  maxnet_frontend_if.slave    bus,
  output logic                mx_start,
  output logic [W-1:0]        mx_epsilon,
  output logic [W-1:0]        mx_a1,
  output logic [W-1:0]        mx_a2,
  output logic [W-1:0]        mx_a3,
  output logic [W-1:0]        mx_a4,
  input  logic                mx_finish,
  input  logic [W-1:0]        mx_out,
  output logic                busy,
  output logic [15:0]         frame_cnt
);

  localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TimerLast = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {StLoad, StStart, StWait, StResult} state_e;

  state_e        state_q, state_d;
  logic [2:0]    idx_q;
  logic [W-1:0]  slot_q [5];
  logic          in_ready_q;
  logic          armed_q;
  logic [TW-1:0] timer_q;
  logic [W-1:0]  res_data_q;
  logic          res_err_q;
  logic [15:0]   frame_cnt_q;

  logic accept, capture, timeout, res_hs;

  // Handshake and WAIT exit conditions; a same-cycle capture suppresses the timeout.
  always_comb begin
    accept  = bus.in_valid & in_ready_q;
    capture = (state_q == StWait) & armed_q & mx_finish;
    timeout = (state_q == StWait) & (TIMEOUT != 0) & (timer_q == TimerLast) & ~capture;
    res_hs  = (state_q == StResult) & bus.res_ready;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:   if (accept && idx_q == 3'd4) state_d = StStart;
      StStart:  state_d = StWait;
      StWait:   if (capture || timeout) state_d = StResult;
      StResult: if (bus.res_ready) state_d = StLoad;
      default:  state_d = StLoad;
    endcase
  end

  // State, word index, ready flag and frame counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StLoad;
      idx_q       <= 3'd0;
      in_ready_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      // Registered so ready is never a combinational function of the handshake inputs.
      in_ready_q <= (state_d == StLoad);
      if (accept) idx_q <= idx_q + 3'd1;
      if (res_hs) begin
        idx_q       <= 3'd0;
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  // Operand slots; only written by accepted words, so they hold through the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) slot_q[i] <= '0;
    end else if (accept) begin
      slot_q[idx_q] <= bus.in_data;
    end
  end

  // Stale-finish guard and watchdog: a finish only counts after it was seen low in WAIT.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
      timer_q <= '0;
    end else if (state_q == StStart) begin
      armed_q <= 1'b0;
      timer_q <= '0;
    end else if (state_q == StWait) begin
      if (!mx_finish) armed_q <= 1'b1;
      timer_q <= timer_q + 1'b1;
    end
  end

  // Result capture; held unchanged while RESULT waits for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else if (capture) begin
      res_data_q <= mx_out;
      res_err_q  <= 1'b0;
    end else if (timeout) begin
      res_data_q <= '0;
      res_err_q  <= 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = (state_q == StResult);
  assign bus.res_data  = res_data_q;
  assign bus.res_err   = res_err_q;
  assign mx_start      = (state_q == StStart);
  assign busy          = (state_q == StStart) || (state_q == StWait);
  assign frame_cnt     = frame_cnt_q;
  assign mx_epsilon    = slot_q[0];
  assign mx_a1         = slot_q[1];
  assign mx_a2         = slot_q[2];
  assign mx_a3         = slot_q[3];
  assign mx_a4         = slot_q[4];

endmodule

// File: tb/tb_maxnet_frontend.sv
// Bench for maxnet_frontend: table of directed frames, hand-written reset/backpressure
// sequences and randomized frames checked against a schedule-based result model.
module tb_maxnet_frontend;
  localparam int unsigned W  = 32;
  localparam int          TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mx_start, mx_finish, busy;
  logic [W-1:0] mx_epsilon, mx_a1, mx_a2, mx_a3, mx_a4, mx_out;
  logic [15:0] frame_cnt;
  logic [W-1:0] ops [5];

  maxnet_frontend_if #(.W(W)) bus ();

  maxnet_frontend #(.W(W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .mx_start   (mx_start),
    .mx_epsilon (mx_epsilon),
    .mx_a1      (mx_a1),
    .mx_a2      (mx_a2),
    .mx_a3      (mx_a3),
    .mx_a4      (mx_a4),
    .mx_finish  (mx_finish),
    .mx_out     (mx_out),
    .busy       (busy),
    .frame_cnt  (frame_cnt)
  );

  assign ops[0] = mx_epsilon;
  assign ops[1] = mx_a1;
  assign ops[2] = mx_a2;
  assign ops[3] = mx_a3;
  assign ops[4] = mx_a4;

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_frames = 0;
  logic [W-1:0] frm [5];

  always @(posedge clk) cyc <= cyc + 1;

  // Core stub: fin_sched[j]/out_sched[j] drive the j-th cycle after the start pulse.
  logic         fin_sched [64];
  logic [W-1:0] out_sched [64];
  int k = 0;

  function automatic int next_k(input logic start, input int kk);
    if (start) return 1;
    if (kk != 0 && kk < 63) return kk + 1;
    return kk;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      k         <= 0;
      mx_finish <= 1'b0;
      mx_out    <= '0;
    end else begin
      k         <= next_k(mx_start, k);
      mx_finish <= (next_k(mx_start, k) != 0) ? fin_sched[next_k(mx_start, k)] : 1'b0;
      mx_out    <= (next_k(mx_start, k) != 0) ? out_sched[next_k(mx_start, k)] : '0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Finish held high for cycles 1..stale_len (stale), then high again from 'delay' unless never.
  task automatic set_sched(input int stale_len, input logic [W-1:0] stale_out, input int delay,
                           input logic [W-1:0] fout, input bit never);
    for (int j = 0; j < 64; j++) begin
      if (j >= 1 && j <= stale_len) begin
        fin_sched[j] = 1'b1;
        out_sched[j] = stale_out;
      end else if (!never && j >= delay && j >= 1) begin
        fin_sched[j] = 1'b1;
        out_sched[j] = fout;
      end else begin
        fin_sched[j] = 1'b0;
        out_sched[j] = $urandom;
      end
    end
  endtask

  // Result = out at the first finish that follows a low finish, if within TO WAIT cycles.
  task automatic model(output logic [W-1:0] data, output bit err, output int lat);
    int z, c;
    z = 0;
    c = 0;
    for (int j = 1; j < 64; j++) if (z == 0 && !fin_sched[j]) z = j;
    if (z != 0) for (int j = z + 1; j < 64; j++) if (c == 0 && fin_sched[j]) c = j;
    if (c != 0 && c <= TO) begin
      data = out_sched[c];
      err  = 1'b0;
      lat  = c + 1;
    end else begin
      data = '0;
      err  = 1'b1;
      lat  = TO + 1;
    end
  endtask

  task automatic send_word(input logic [W-1:0] w, input int gap);
    int bound;
    bus.in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    bound = 0;
    while (!bus.in_ready && bound < 200) begin @(posedge clk); #1; bound++; end
    if (bound >= 200) check("in_ready_timeout", 0, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input int gap, input int hold, input logic [W-1:0] exp_data,
                           input bit exp_err, input int exp_lat);
    int s, bound;
    bit quiet, stable;
    for (int i = 0; i < 5; i++) send_word(frm[i], gap);
    check("start_after_5th", mx_start, 1);
    check("busy_start", busy, 1);
    check("ready_drop", bus.in_ready, 0);
    for (int i = 0; i < 5; i++) check("operand", ops[i], frm[i]);
    s = cyc;
    // Junk offered while busy must not be consumed.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    check("start_one_cycle", mx_start, 0);
    quiet = 1'b1;
    bound = 0;
    while (!bus.res_valid && bound < 200) begin
      if (bus.in_ready || mx_start || !busy) quiet = 1'b0;
      @(posedge clk); #1;
      bound++;
    end
    check("res_valid_seen", bus.res_valid, 1);
    check("res_latency", cyc - s, exp_lat);
    check("res_data", bus.res_data, exp_data);
    check("res_err", bus.res_err, exp_err);
    check("quiet_in_wait", quiet, 1);
    check("busy_result", busy, 0);
    stable = 1'b1;
    bus.res_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      if (!bus.res_valid || bus.res_data !== exp_data || bus.res_err !== exp_err ||
          bus.in_ready) stable = 1'b0;
    end
    check("result_held", stable, 1);
    for (int i = 0; i < 5; i++) check("operand_held", ops[i], frm[i]);
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.in_valid  = 1'b0;
    exp_frames++;
    check("res_valid_drop", bus.res_valid, 0);
    check("frame_cnt", frame_cnt, exp_frames[15:0]);
    check("ready_after_result", bus.in_ready, 1);
  endtask

  task automatic do_reset_checks(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    check({tag, "_in_ready"}, bus.in_ready, 0);
    check({tag, "_mx_start"}, mx_start, 0);
    check({tag, "_res_valid"}, bus.res_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_res_data"}, bus.res_data, 0);
    check({tag, "_res_err"}, bus.res_err, 0);
    check({tag, "_eps"}, mx_epsilon, 0);
    check({tag, "_a4"}, mx_a4, 0);
    rst = 1'b0;
    exp_frames = 0;
  endtask

  typedef struct {
    logic [W-1:0] w0, w1, w2, w3, w4;
    int           stale_len;
    logic [W-1:0] stale_out;
    int           delay;
    logic [W-1:0] fout;
    bit           never;
    logic [W-1:0] exp_data;
    bit           exp_err;
    int           exp_lat;
  } vec_t;

  vec_t tbl [7];

  initial begin
    logic [W-1:0] md;
    bit me;
    int ml, bound;

    tbl[0] = '{1, 5, 9, 3, 7, 0, 0, 6, 9, 0, 9, 0, 7};
    tbl[1] = '{11, 12, 13, 14, 15, 3, 32'hDEAD, 5, 4, 0, 4, 0, 6};
    tbl[2] = '{21, 22, 23, 24, 25, 0, 0, 1, 0, 1, 0, 1, 17};
    tbl[3] = '{31, 32, 33, 34, 35, 0, 0, 16, 32'h1234, 0, 32'h1234, 0, 17};
    tbl[4] = '{41, 42, 43, 44, 45, 0, 0, 17, 32'h55, 0, 0, 1, 17};
    tbl[5] = '{51, 52, 53, 54, 55, 2, 32'hDEAD, 3, 32'h77, 0, 0, 1, 17};
    tbl[6] = '{61, 62, 63, 64, 65, 14, 32'hDEAD, 16, 32'hAB, 0, 32'hAB, 0, 17};

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.res_ready = 1'b0;
    set_sched(0, 0, 1, 0, 1'b1);

    repeat (2) @(posedge clk);
    #1;
    do_reset_checks("reset");

    // Directed table.
    for (int t = 0; t < 7; t++) begin
      frm[0] = tbl[t].w0; frm[1] = tbl[t].w1; frm[2] = tbl[t].w2;
      frm[3] = tbl[t].w3; frm[4] = tbl[t].w4;
      set_sched(tbl[t].stale_len, tbl[t].stale_out, tbl[t].delay, tbl[t].fout, tbl[t].never);
      run_frame(0, 0, tbl[t].exp_data, tbl[t].exp_err, tbl[t].exp_lat);
    end

    // Gapped input and a consumer that stalls for 10 cycles.
    frm[0] = 1; frm[1] = 5; frm[2] = 9; frm[3] = 3; frm[4] = 7;
    set_sched(0, 0, 6, 9, 1'b0);
    run_frame(1, 10, 9, 1'b0, 7);

    // Reset after three words: partial frame discarded, counter restarts.
    frm[0] = 100; frm[1] = 101; frm[2] = 102;
    for (int i = 0; i < 3; i++) send_word(frm[i], 0);
    do_reset_checks("midframe_rst");
    frm[0] = 2; frm[1] = 8; frm[2] = 6; frm[3] = 1; frm[4] = 4;
    set_sched(0, 0, 4, 32'hC0DE, 1'b0);
    run_frame(0, 2, 32'hC0DE, 1'b0, 5);

    // Reset during WAIT.
    set_sched(0, 0, 1, 0, 1'b1);
    for (int i = 0; i < 5; i++) send_word(frm[i], 0);
    repeat (3) begin @(posedge clk); #1; end
    do_reset_checks("midrun_rst");

    // Reset with a result pending.
    set_sched(0, 0, 2, 32'h4242, 1'b0);
    for (int i = 0; i < 5; i++) send_word(frm[i], 0);
    bound = 0;
    while (!bus.res_valid && bound < 100) begin @(posedge clk); #1; bound++; end
    check("pending_res_valid", bus.res_valid, 1);
    do_reset_checks("pending_rst");

    // Randomized frames against the schedule model.
    for (int n = 0; n < 30; n++) begin
      int sl, dl, gp, hd;
      bit nv;
      for (int i = 0; i < 5; i++) frm[i] = $urandom;
      sl = $urandom_range(0, 4);
      dl = $urandom_range(1, 20);
      nv = ($urandom_range(0, 7) == 0);
      gp = $urandom_range(0, 2);
      hd = $urandom_range(0, 3);
      set_sched(sl, $urandom, dl, $urandom, nv);
      model(md, me, ml);
      run_frame(gp, hd, md, me, ml);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end
endmodule
